// File: rtl/count_pkg.sv
// Shared constants and helpers for the up/down/load counter family.
package count_pkg;

  // Default counter / load-data width.
  localparam int unsigned CNT_WIDTH_DEF = 8;

  // Counter reset value; all zeros at any width.
  localparam int unsigned CNT_RST_VAL = 0;

  // Operation selected at a rising edge, already priority-resolved.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_LOAD = 2'd3
  } cnt_op_e;

  // Priority: load > en > hold; ud only selects direction when counting.
  function automatic cnt_op_e decode_op(input logic en, input logic ud, input logic load);
    cnt_op_e op;
    if (load)    op = OP_LOAD;
    else if (en) op = ud ? OP_UP : OP_DOWN;
    else         op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/count_udl_next.sv
// Combinational next-state logic for count_udl.
module count_udl_next
  import count_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] cnt_next
);

  cnt_op_e op;

  // Resolve the operation and compute the wrapped next count.
  always_comb begin
    cnt_next = cnt;
    op       = decode_op(en, ud, load);
    unique case (op)
      OP_LOAD: cnt_next = d;
      OP_UP:   cnt_next = cnt + WIDTH'(1);
      OP_DOWN: cnt_next = cnt - WIDTH'(1);
      default: cnt_next = cnt;
    endcase
  end

endmodule

// File: rtl/count_udl.sv
// Up/down counter with synchronous parallel load and asynchronous reset.
module count_udl
  import count_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEF
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_next;

  count_udl_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .cnt      (cnt),
    .en       (en),
    .ud       (ud),
    .load     (load),
    .d        (d),
    .cnt_next (cnt_next)
  );

  // State register; reset clears it immediately, independent of ck.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) cnt <= WIDTH'(CNT_RST_VAL);
    else       cnt <= cnt_next;
  end

endmodule

// File: tb/tb_count_udl.sv
// Self-checking bench for count_udl (WIDTH = 8).
module tb_count_udl;

  localparam int unsigned W = 8;

  logic         ck;
  logic         reset;
  logic         en;
  logic         ud;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic         en;
    logic         ud;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] exp;
  } sb_t;

  vec_t vecs1[$];
  vec_t vecs2[$];
  sb_t  sb[$];

  count_udl #(
    .WIDTH(W)
  ) dut (
    .ck    (ck),
    .reset (reset),
    .en    (en),
    .ud    (ud),
    .load  (load),
    .d     (d),
    .cnt   (cnt)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cnt=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input logic e, input logic u, input logic l,
                              input logic [W-1:0] dd, input logic [W-1:0] x);
    vec_t v;
    v.name = name; v.en = e; v.ud = u; v.load = l; v.d = dd; v.exp = x;
    return v;
  endfunction

  // Drive a vector away from the edge, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    sb_t s;
    @(negedge ck);
    en = v.en; ud = v.ud; load = v.load; d = v.d;
    s.name = v.name; s.exp = v.exp;
    sb.push_back(s);
    @(posedge ck);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      s = sb.pop_front();
      check(s.name, cnt, s.exp);
    end
  endtask

  initial begin
    // Up-count from reset, then hold.
    vecs1.push_back(mk("up1",   1, 1, 0, 8'h00, 8'h01));
    vecs1.push_back(mk("up2",   1, 1, 0, 8'h00, 8'h02));
    vecs1.push_back(mk("up3",   1, 1, 0, 8'h00, 8'h03));
    vecs1.push_back(mk("up4",   1, 1, 0, 8'h00, 8'h04));
    vecs1.push_back(mk("up5",   1, 1, 0, 8'h00, 8'h05));
    vecs1.push_back(mk("hold1", 0, 1, 0, 8'hAA, 8'h05));
    vecs1.push_back(mk("hold2", 0, 0, 0, 8'h55, 8'h05));
    // After reset: first edge decrements from 0, then load/down/up/wrap.
    vecs2.push_back(mk("first_down_wrap", 1, 0, 0, 8'h00, 8'hFF));
    vecs2.push_back(mk("load5",   0, 0, 1, 8'h05, 8'h05));
    vecs2.push_back(mk("dn4",     1, 0, 0, 8'h00, 8'h04));
    vecs2.push_back(mk("dn3",     1, 0, 0, 8'h00, 8'h03));
    vecs2.push_back(mk("dn2",     1, 0, 0, 8'h00, 8'h02));
    vecs2.push_back(mk("dn1",     1, 0, 0, 8'h00, 8'h01));
    vecs2.push_back(mk("load0F_prio", 1, 0, 1, 8'h0F, 8'h0F));
    vecs2.push_back(mk("up10",    1, 1, 0, 8'h00, 8'h10));
    vecs2.push_back(mk("up11",    1, 1, 0, 8'h00, 8'h11));
    vecs2.push_back(mk("up12",    1, 1, 0, 8'h00, 8'h12));
    vecs2.push_back(mk("up13",    1, 1, 0, 8'h00, 8'h13));
    vecs2.push_back(mk("loadFF",  0, 1, 1, 8'hFF, 8'hFF));
    vecs2.push_back(mk("up_wrap", 1, 1, 0, 8'h00, 8'h00));
    vecs2.push_back(mk("dn_wrap", 1, 0, 0, 8'h00, 8'hFF));
    vecs2.push_back(mk("load_en0", 0, 0, 1, 8'h3C, 8'h3C));
    vecs2.push_back(mk("ud_up",   1, 1, 0, 8'h00, 8'h3D));
    vecs2.push_back(mk("ud_dn",   1, 0, 0, 8'h00, 8'h3C));
    vecs2.push_back(mk("ud_up2",  1, 1, 0, 8'h00, 8'h3D));
    vecs2.push_back(mk("hold3",   0, 1, 0, 8'h77, 8'h3D));

    en = 0; ud = 1; load = 0; d = '0;
    reset = 1'b1;
    #1;
    check("reset_async_initial", cnt, 8'h00);

    // Reset held for 2 clocks while load/en are active: must stay 0.
    en = 1; load = 1; d = 8'hAA;
    for (int unsigned i = 0; i < 2; i++) begin
      @(posedge ck); #1;
      check("reset_hold", cnt, 8'h00);
    end
    @(negedge ck);
    reset = 1'b0; en = 0; load = 0; d = '0;
    #1;
    check("reset_release", cnt, 8'h00);

    foreach (vecs1[i]) apply(vecs1[i]);

    // Reset between edges at cnt=5 with a pending up-count.
    @(negedge ck);
    en = 1; ud = 1;
    #2;
    reset = 1'b1;
    #1;
    check("reset_midcycle", cnt, 8'h00);
    @(posedge ck); #1;
    check("reset_high_edge", cnt, 8'h00);
    @(negedge ck);
    en = 0;
    reset = 1'b0;
    @(posedge ck); #1;
    check("no_pending_after_reset", cnt, 8'h00);

    foreach (vecs2[i]) apply(vecs2[i]);

    // Glitch on en/load between edges must not be sampled.
    @(negedge ck);
    en = 1; load = 1; d = 8'h99;
    #2;
    en = 0; load = 0;
    @(posedge ck); #1;
    check("glitch_ignored", cnt, 8'h3D);

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover size=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_udl.md
COUNT_UDL -- requirements
Module: count_udl

Interface
REQ-001 Parameter WIDTH, default 8: counter and load-data width in bits (minimum 2).
REQ-002 ck  input  1  clock; all state changes on the rising edge except reset.
REQ-003 reset  input  1  asynchronous, active-high reset; clears the counter.
REQ-004 en  input  1  count enable; 1 = count on the next rising edge, 0 = hold.
REQ-005 ud  input  1  direction; 1 = up (+1), 0 = down (-1).
REQ-006 load  input  1  synchronous parallel-load request.
REQ-007 d  input  WIDTH  parallel-load data.
REQ-008 cnt  output  WIDTH  current count value, driven directly from the state register.
REQ-009 Clocking is fixed: one clock (ck); reset is asynchronous and active-high.

Function
REQ-010 The block SHALL hold one WIDTH-bit register whose value is cnt.
REQ-011 Priority SHALL be reset > load > en > hold.
REQ-012 With load=1 at a rising edge, cnt SHALL take d on that edge, regardless of en and ud.
REQ-013 With load=0, en=1, ud=1 at a rising edge, cnt SHALL become (cnt+1) mod 2^WIDTH.
REQ-014 With load=0, en=1, ud=0 at a rising edge, cnt SHALL become (cnt-1) mod 2^WIDTH.
REQ-015 With load=0 and en=0, cnt SHALL hold its value.
REQ-016 Wrap-around: all-ones counting up SHALL give 0; 0 counting down SHALL give all-ones. No carry, terminal-count or error output exists.
REQ-017 Latency: each operation SHALL be visible on cnt one rising edge after the inputs are sampled. There is no combinational path from inputs to cnt.
REQ-018 A change of ud while en=1 SHALL take effect on the very next edge, with no idle cycle.
REQ-019 Inputs SHALL be sampled only at rising edges; glitches between edges have no effect.

Reset
REQ-020 reset=1 SHALL force cnt to 0 immediately, without waiting for a clock edge.
REQ-021 While reset=1, cnt SHALL stay 0 regardless of en, load, ud, d or ck.
REQ-022 After reset deasserts, the first rising edge SHALL apply REQ-011..REQ-015 from cnt=0.
REQ-023 Reset asserted mid-count SHALL discard the count in progress; no pending operation survives it.
REQ-024 After power-up, cnt SHALL be undefined until reset is first asserted.

Structure
REQ-025 WIDTH's default value (8) SHALL live in a shared package (count_pkg) as constant CNT_WIDTH_DEF.
REQ-026 The reset value (all zeros) SHALL also live in count_pkg.
REQ-027 An optional combinational sub-module, count_udl_next, SHALL compute the next value from (cnt, en, ud, load, d).
REQ-028 count_udl SHALL contain only the state register, including its asynchronous reset.
REQ-029 The design SHALL be synthesizable with no latches and one clock domain.

Verification
REQ-030 Assert reset for 2 clocks, then en=1, ud=1 for 5 clocks -> cnt = 0,1,2,3,4,5.
REQ-031 en=0 for 2 clocks at cnt=5 -> cnt stays 5.
REQ-032 Assert reset between clock edges with cnt=5 -> cnt=0 before the next rising edge, and it stays 0 while reset is high.
REQ-033 From cnt=5: ud=0, en=1 for 4 clocks -> cnt = 4,3,2,1.
REQ-034 load=1, d=0x0F for 1 clock, then up-count for 4 clocks -> cnt = 0x0F,0x10,0x11,0x12,0x13.
REQ-035 Load 0xFF and count up once -> cnt=0x00; then count down once -> cnt=0xFF.
REQ-036 load=1 with en=0 -> cnt=d.
